cc_seqcomparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator; next generation of the combinational comparator block.
- Compares two NUMBER_DATAWIDTH operands MSB-first, NUMBER_DIGITWIDTH bits per cycle, under a start/busy/done handshake.
- Supports unsigned or two's-complement mode, selected per operation.
- Results are registered and held between operations; the block sits between datapath registers and control FSMs that need a cheap, wide compare.

---
 rtl/cc_seqcomparator_pkg.sv | 22 ++
 rtl/cc_seqcomparator_digit.sv | 14 +
 rtl/cc_seqcomparator.sv | 137 +++++++++++++
 tb/tb_cc_seqcomparator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_seqcomparator_pkg.sv
// Shared types and sizing helpers for the multi-cycle magnitude comparator.
package cc_seqcomparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam logic [1:0] VERDICT_EQ = 2'd0;
  localparam logic [1:0] VERDICT_GT = 2'd1;
  localparam logic [1:0] VERDICT_LT = 2'd2;

  function automatic int calc_steps(input int data_w, input int digit_w);
    return data_w / digit_w;
  endfunction

  function automatic int calc_cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/cc_seqcomparator_digit.sv
// Combinational unsigned compare of one digit slice of the two operands.
module cc_seqcomparator_digit #(
  parameter int NUMBER_DIGITWIDTH = 2
) (
  input  logic [NUMBER_DIGITWIDTH-1:0] a_i,
  input  logic [NUMBER_DIGITWIDTH-1:0] b_i,
  output logic                         digit_gt_o,
  output logic                         digit_lt_o
);

  assign digit_gt_o = (a_i > b_i);
  assign digit_lt_o = (a_i < b_i);

endmodule

// File: rtl/cc_seqcomparator.sv
// MSB-first digit-serial magnitude comparator with start/busy/done handshake.
// Define CC_SEQCOMPARATOR_EARLYEXIT_EN to finish on the first unequal digit.
module cc_seqcomparator
  import cc_seqcomparator_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_DIGITWIDTH = 2
) (
  input  logic                        CC_SEQCOMPARATOR_CLOCK_50,
  input  logic                        CC_SEQCOMPARATOR_RESET_InHigh,
  input  logic                        CC_SEQCOMPARATOR_start_In,
  input  logic                        CC_SEQCOMPARATOR_signed_In,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_SEQCOMPARATOR_dataA_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_SEQCOMPARATOR_dataB_InBUS,
  output logic                        CC_SEQCOMPARATOR_busy_Out,
  output logic                        CC_SEQCOMPARATOR_done_Out,
  output logic                        CC_SEQCOMPARATOR_greaterthan_Out,
  output logic                        CC_SEQCOMPARATOR_lessthan_Out,
  output logic                        CC_SEQCOMPARATOR_equal_Out
);

  localparam int NUMBER_STEPS = calc_steps(NUMBER_DATAWIDTH, NUMBER_DIGITWIDTH);
  localparam int CNT_W        = calc_cnt_width(NUMBER_STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUMBER_STEPS - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [NUMBER_DATAWIDTH-1:0] MSB_MASK =
    NUMBER_DATAWIDTH'(1) << (NUMBER_DATAWIDTH - 1);

`ifdef CC_SEQCOMPARATOR_EARLYEXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  state_e                      state_q, state_d;
  logic [NUMBER_DATAWIDTH-1:0] a_q, a_d;
  logic [NUMBER_DATAWIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  verdict_q, verdict_d;
  logic [1:0]                  verdict_step;
  logic                        gt_q, gt_d;
  logic                        lt_q, lt_d;
  logic                        eq_q, eq_d;
  logic                        digit_gt;
  logic                        digit_lt;
  logic [NUMBER_DATAWIDTH-1:0] sign_mask;

  cc_seqcomparator_digit #(
    .NUMBER_DIGITWIDTH(NUMBER_DIGITWIDTH)
  ) u_digit (
    .a_i       (a_q[NUMBER_DATAWIDTH-1 -: NUMBER_DIGITWIDTH]),
    .b_i       (b_q[NUMBER_DATAWIDTH-1 -: NUMBER_DIGITWIDTH]),
    .digit_gt_o(digit_gt),
    .digit_lt_o(digit_lt)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    verdict_d    = verdict_q;
    gt_d         = gt_q;
    lt_d         = lt_q;
    eq_d         = eq_q;
    sign_mask    = CC_SEQCOMPARATOR_signed_In ? MSB_MASK : '0;

    // Once a digit differs the verdict is frozen for the rest of the scan.
    verdict_step = verdict_q;
    if (verdict_q == VERDICT_EQ) begin
      if (digit_gt) begin
        verdict_step = VERDICT_GT;
      end else if (digit_lt) begin
        verdict_step = VERDICT_LT;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (CC_SEQCOMPARATOR_start_In) begin
          a_d       = CC_SEQCOMPARATOR_dataA_InBUS ^ sign_mask;
          b_d       = CC_SEQCOMPARATOR_dataB_InBUS ^ sign_mask;
          cnt_d     = '0;
          verdict_d = VERDICT_EQ;
          state_d   = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        a_d       = a_q << NUMBER_DIGITWIDTH;
        b_d       = b_q << NUMBER_DIGITWIDTH;
        cnt_d     = cnt_q + 1'b1;
        verdict_d = verdict_step;
        if ((cnt_q == LAST_CNT) || (EARLY_EXIT && (verdict_step != VERDICT_EQ))) begin
          gt_d    = (verdict_step == VERDICT_GT);
          lt_d    = (verdict_step == VERDICT_LT);
          eq_d    = (verdict_step == VERDICT_EQ);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CC_SEQCOMPARATOR_CLOCK_50) begin
    if (CC_SEQCOMPARATOR_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      verdict_q <= VERDICT_EQ;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      verdict_q <= verdict_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
    end
  end

  assign CC_SEQCOMPARATOR_busy_Out        = (state_q != ST_IDLE);
  assign CC_SEQCOMPARATOR_done_Out        = (state_q == ST_DONE);
  assign CC_SEQCOMPARATOR_greaterthan_Out = gt_q;
  assign CC_SEQCOMPARATOR_lessthan_Out    = lt_q;
  assign CC_SEQCOMPARATOR_equal_Out       = eq_q;

endmodule

// File: tb/tb_cc_seqcomparator.sv
// Directed bench for cc_seqcomparator (8-bit operands, 2-bit digits, 4 steps).
module tb_cc_seqcomparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sgn;
  logic [7:0] da;
  logic [7:0] db;
  logic       busy, done, gt, lt, eq;

  int vectors     = 0;
  int miscompares = 0;

`ifdef CC_SEQCOMPARATOR_EARLYEXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_EQ = 3'b001;

  always #5 clk = ~clk;

  cc_seqcomparator #(
    .NUMBER_DATAWIDTH (8),
    .NUMBER_DIGITWIDTH(2)
  ) dut (
    .CC_SEQCOMPARATOR_CLOCK_50       (clk),
    .CC_SEQCOMPARATOR_RESET_InHigh   (rst),
    .CC_SEQCOMPARATOR_start_In       (start),
    .CC_SEQCOMPARATOR_signed_In      (sgn),
    .CC_SEQCOMPARATOR_dataA_InBUS    (da),
    .CC_SEQCOMPARATOR_dataB_InBUS    (db),
    .CC_SEQCOMPARATOR_busy_Out       (busy),
    .CC_SEQCOMPARATOR_done_Out       (done),
    .CC_SEQCOMPARATOR_greaterthan_Out(gt),
    .CC_SEQCOMPARATOR_lessthan_Out   (lt),
    .CC_SEQCOMPARATOR_equal_Out      (eq)
  );

  // Cycle in which done is expected, given the index k of the first unequal digit.
  function automatic int exp_cyc(input int k);
    return EE ? k + 1 : 5;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input int k, input logic [2:0] exp_gle, input string name);
    int  cyc;
    bit  found;
    @(negedge clk);
    da = a; db = b; sgn = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    cyc   = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        cyc   = c;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL %s_timeout: done=%b never seen, required within 20 cycles", name, done);
    end else begin
      vectors++;
      if (cyc !== exp_cyc(k)) begin
        miscompares++;
        $display("FAIL %s_latency: done in cycle %0d, required %0d", name, cyc, exp_cyc(k));
      end
      vectors++;
      if ({gt, lt, eq} !== exp_gle) begin
        miscompares++;
        $display("FAIL %s_verdict: gt/lt/eq=%b, required %b", name, {gt, lt, eq}, exp_gle);
      end
      $display("tb: %s A=%h B=%h signed=%0d done_cycle=%0d gt/lt/eq=%b",
               name, a, b, s, cyc, {gt, lt, eq});
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, gt, lt, eq} !== {2'b00, exp_gle}) begin
      miscompares++;
      $display("FAIL %s_hold: busy/done/gt/lt/eq=%b, required %b",
               name, {busy, done, gt, lt, eq}, {2'b00, exp_gle});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; da = 8'h00; db = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, gt, lt, eq} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_held: busy/done/gt/lt/eq=%b, required 00000", {busy, done, gt, lt, eq});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, gt, lt, eq} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_released: busy/done/gt/lt/eq=%b, required 00000", {busy, done, gt, lt, eq});
    end
    $display("tb: reset checked");
  endtask

  task automatic test_unsigned;
    run_op(8'hC0, 8'h40, 1'b0, 1, R_GT, "unsigned_top_digit");
    run_op(8'h5A, 8'h5A, 1'b0, 4, R_EQ, "unsigned_equal");
    repeat (2) @(negedge clk);
    vectors++;
    if ({gt, lt, eq} !== R_EQ) begin
      miscompares++;
      $display("FAIL equal_hold_long: gt/lt/eq=%b, required %b", {gt, lt, eq}, R_EQ);
    end
  endtask

  task automatic test_signed;
    run_op(8'hFF, 8'h01, 1'b1, 1, R_LT, "signed_neg_vs_pos");
    run_op(8'hFF, 8'h01, 1'b0, 1, R_GT, "unsigned_ff_vs_01");
  endtask

  task automatic test_last_digit;
    run_op(8'h03, 8'h02, 1'b0, 4, R_GT, "last_digit");
  endtask

  task automatic test_back_to_back;
    int  cyc;
    bit  found;
    @(negedge clk);
    da = 8'h20; db = 8'h80; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    found = 1'b0;
    cyc   = 0;
    // start stays high; operands and mode churn while the first compare runs
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        cyc   = c;
        da = 8'hFF; db = 8'h00; sgn = 1'b0;
      end else begin
        da  = da + 8'h35;
        db  = db ^ 8'hA5;
        sgn = ~sgn;
      end
    end
    vectors++;
    if (!found || cyc !== exp_cyc(1) || {gt, lt, eq} !== R_LT) begin
      miscompares++;
      $display("FAIL b2b_first: found=%0d cycle=%0d gt/lt/eq=%b, required cycle %0d gt/lt/eq=%b",
               found, cyc, {gt, lt, eq}, exp_cyc(1), R_LT);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle_gap: busy/done=%b, required 00", {busy, done});
    end
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    cyc   = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
      end
      if (done) begin
        found = 1'b1;
        cyc   = c;
      end
    end
    vectors++;
    if (!found || cyc !== exp_cyc(1) || {gt, lt, eq} !== R_GT) begin
      miscompares++;
      $display("FAIL b2b_second: found=%0d cycle=%0d gt/lt/eq=%b, required cycle %0d gt/lt/eq=%b",
               found, cyc, {gt, lt, eq}, exp_cyc(1), R_GT);
    end
    $display("tb: back_to_back first_cycle=%0d second_cycle=%0d gt/lt/eq=%b", exp_cyc(1), cyc, {gt, lt, eq});
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    da = 8'h5A; db = 8'h5A; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, gt, lt, eq} !== 5'b00000) begin
      miscompares++;
      $display("FAIL midreset_clear: busy/done/gt/lt/eq=%b, required 00000", {busy, done, gt, lt, eq});
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done} !== 2'b00) begin
        miscompares++;
        $display("FAIL midreset_no_done: busy/done=%b, required 00", {busy, done});
      end
    end
    $display("tb: mid-operation reset checked");
    run_op(8'h10, 8'h20, 1'b0, 2, R_LT, "after_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_last_digit();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
